fp4_fft_stream_ctrl: RTL and testbench

//  Host-side initiator for fp4_fft_top's external load/read ports. Sits between an upstream

---
 rtl/fp4_fft_stream_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fp4_fft_stream_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp4_fft_stream_ctrl.sv
// fp4_fft_stream_ctrl
//   Host-side initiator for fp4_fft_top's external load/read ports. Runs one
//   frame at a time: loads N complex FP4 samples into FFT memory, pulses
//   fft_start, waits for fft_done, then streams the N results out in natural
//   order through a 2-entry output FIFO.
//
// Ports
//   clk, rst (async, active low)
//   cfg_len_m1              frame length N-1, latched on the first accepted sample
//   in_valid/in_ready/in_data      upstream sample stream {re[7:4],im[3:0]}
//   out_valid/out_ready/out_data/out_last   downstream result stream
//   ext_wr_en/ext_wr_addr/ext_wr_data       fp4_fft_top load port
//   fft_start/fft_done                      fp4_fft_top handshake
//   ext_rd_addr/ext_rd_data                 fp4_fft_top read port (RD_LAT latency)
//   busy                    high whenever not IDLE
//   err                     sticky done-wait timeout flag
//
// Optional feature: define FFT_CTRL_TIMEOUT_EN to abort a frame whose
// fft_done does not arrive within TMO_CYCLES cycles in WAIT_DONE.
module fp4_fft_stream_ctrl #(
    parameter int MAX_N      = 32,
    parameter int ADDR_WIDTH = $clog2(MAX_N),
    parameter int RD_LAT     = 1,
    parameter int TMO_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cfg_len_m1,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  ext_wr_en,
    output logic [ADDR_WIDTH-1:0] ext_wr_addr,
    output logic [7:0]            ext_wr_data,
    output logic                  fft_start,
    input  logic                  fft_done,
    output logic [ADDR_WIDTH-1:0] ext_rd_addr,
    input  logic [7:0]            ext_rd_data,
    output logic                  busy,
    output logic                  err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_UNLOAD = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH:0]   rd_cnt;      // one extra bit: runs to len+1
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [RD_LAT:1]       vld_pipe;    // reads in flight, stage RD_LAT = data arriving now
    logic [RD_LAT:1]       lst_pipe;    // last-address tag travelling with each read

    logic [1:0][7:0]       fifo_data;
    logic [1:0]            fifo_last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            fifo_cnt;

    logic                  accept, issue, push, pop;
    logic [1:0]            inflight;
    logic [2:0]            occ;

    assign in_ready    = (state == S_IDLE) || (state == S_LOAD);
    assign accept      = in_valid & in_ready;
    assign ext_wr_en   = accept;
    assign ext_wr_addr = (state == S_LOAD) ? wr_cnt : '0;
    assign ext_wr_data = accept ? in_data : 8'h00;
    assign fft_start   = (state == S_START);
    assign busy        = (state != S_IDLE);

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = vld_pipe[RD_LAT];

    // Occupancy counts the pop happening this cycle so a full-rate stream
    // keeps issuing one read per cycle with only two FIFO slots.
    always_comb begin
        inflight = 2'd0;
        for (int i = 1; i <= RD_LAT; i++) inflight = inflight + 2'(vld_pipe[i]);
    end
    assign occ   = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    assign issue = (state == S_UNLOAD) && (rd_cnt <= {1'b0, len}) && (occ < 3'd2);

    // Address is presented in the issue cycle; otherwise holds the last one.
    assign ext_rd_addr = issue ? rd_cnt[ADDR_WIDTH-1:0] : rd_addr_q;

`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rd_addr_q <= '0;
            vld_pipe  <= '0;
            lst_pipe  <= '0;
`ifdef FFT_CTRL_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    len    <= cfg_len_m1;
                    wr_cnt <= ADDR_WIDTH'(1);
                    state  <= (cfg_len_m1 == '0) ? S_GAP : S_LOAD;
                end
                S_LOAD: if (accept) begin
                    if (wr_cnt == len) state <= S_GAP;
                    else               wr_cnt <= wr_cnt + 1'b1;
                end
                S_GAP:   state <= S_START;
                S_START: begin
                    state <= S_WAIT;
`ifdef FFT_CTRL_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                S_WAIT: begin
`ifdef FFT_CTRL_TIMEOUT_EN
                    if (fft_done) begin
                        state <= S_UNLOAD;
                    end else if (tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`else
                    if (fft_done) state <= S_UNLOAD;
`endif
                end
                S_UNLOAD: if (pop && out_last) state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            if (state != S_UNLOAD) rd_cnt <= '0;
            else if (issue)        rd_cnt <= rd_cnt + 1'b1;
            if (issue) rd_addr_q <= rd_cnt[ADDR_WIDTH-1:0];

            for (int i = RD_LAT; i > 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                lst_pipe[i] <= lst_pipe[i-1];
            end
            vld_pipe[1] <= issue;
            lst_pipe[1] <= issue && (rd_cnt[ADDR_WIDTH-1:0] == len);
        end
    end

    // 2-entry output FIFO; push and pop may coincide even when full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_data <= '0;
            fifo_last <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= ext_rd_data;
                fifo_last[wr_ptr] <= lst_pipe[RD_LAT];
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fp4_fft_stream_ctrl.sv
module tb_fp4_fft_stream_ctrl;
    localparam int AW = 5;
`ifdef FFT_CTRL_TIMEOUT_EN
    localparam int DONE_DLY = 10;
`else
    localparam int DONE_DLY = 40;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] cfg_len_m1 = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_last;
    logic          ext_wr_en;
    logic [AW-1:0] ext_wr_addr;
    logic [7:0]    ext_wr_data;
    logic          fft_start;
    logic          fft_done = 1'b0;
    logic [AW-1:0] ext_rd_addr;
    logic [7:0]    ext_rd_data;
    logic          busy;
    logic          err;

    fp4_fft_stream_ctrl #(.MAX_N(32), .ADDR_WIDTH(AW), .RD_LAT(1), .TMO_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cfg_len_m1(cfg_len_m1),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .fft_start(fft_start), .fft_done(fft_done),
        .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // FFT memory stand-in: results read back equal the loaded samples,
    // one-cycle registered read.
    logic [7:0] fmem [32];
    logic [7:0] rd_q = 8'h00;
    int start_cnt = 0;
    int clash = 0;
    assign ext_rd_data = rd_q;
    always @(posedge clk) begin
        if (ext_wr_en) fmem[ext_wr_addr] <= ext_wr_data;
        rd_q <= fmem[ext_rd_addr];
        if (fft_start) start_cnt++;
        if (fft_start && ext_wr_en) clash++;
    end

    int vecs = 0;
    int errs = 0;

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({busy, ext_wr_en, fft_start, out_valid, out_last, err, ext_wr_addr, ext_rd_addr, out_data} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: busy=%b wr_en=%b start=%b ov=%b last=%b err=%b wa=%0d ra=%0d od=%h, want all 0",
                     busy, ext_wr_en, fft_start, out_valid, out_last, err, ext_wr_addr, ext_rd_addr, out_data);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_idle: busy=%b in_ready=%b, want busy=0 in_ready=1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        int s0;
        s0 = start_cnt;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = 8'h30 + 8'(k); cfg_len_m1 = 5'd7;
            @(negedge clk);
            vecs++;
            if (ext_wr_en !== 1'b1 || ext_wr_addr !== 5'(k)) begin
                errs++;
                $display("FAIL midload_wr[%0d]: en=%b addr=%0d, want en=1 addr=%0d", k, ext_wr_en, ext_wr_addr, k);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        vecs++;
        if ({busy, ext_wr_en, fft_start, out_valid, out_last, err, ext_wr_addr, ext_rd_addr, out_data} !== '0) begin
            errs++;
            $display("FAIL midload_reset: busy=%b wr_en=%b start=%b ov=%b wa=%0d, want all 0",
                     busy, ext_wr_en, fft_start, out_valid, ext_wr_addr);
        end
        @(posedge clk); #1; rst = 1'b1;
        repeat (10) @(posedge clk);
        vecs++;
        if (start_cnt != s0) begin
            errs++;
            $display("FAIL midload_no_start: starts=%0d, want %0d", start_cnt, s0);
        end
    endtask

    // Loads n_m1+1 samples base+i, then checks GAP, START and first WAIT_DONE cycle.
    // cfg_len_m1 is scrambled after the first sample; it must not matter.
    task automatic load_frame(input logic [AW-1:0] n_m1, input logic [7:0] base, input logic done_early);
        for (int i = 0; i <= int'(n_m1); i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = base + 8'(i);
            cfg_len_m1 = (i == 0) ? n_m1 : 5'd2;
            @(negedge clk);
            vecs++;
            if (ext_wr_en !== 1'b1 || ext_wr_addr !== 5'(i) || ext_wr_data !== base + 8'(i) || fft_start !== 1'b0) begin
                errs++;
                $display("FAIL load_wr[%0d]: en=%b addr=%0d data=%h start=%b, want en=1 addr=%0d data=%h start=0",
                         i, ext_wr_en, ext_wr_addr, ext_wr_data, fft_start, i, base + 8'(i));
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'h00; fft_done = done_early;
        @(negedge clk);
        vecs++;
        if ({ext_wr_en, fft_start, busy, in_ready} !== 4'b0010) begin
            errs++;
            $display("FAIL gap: wr_en=%b start=%b busy=%b in_ready=%b, want 0 0 1 0", ext_wr_en, fft_start, busy, in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vecs++;
        if ({fft_start, ext_wr_en} !== 2'b10) begin
            errs++;
            $display("FAIL start_pulse: start=%b wr_en=%b, want start=1 wr_en=0", fft_start, ext_wr_en);
        end
        @(posedge clk); #1; fft_done = 1'b0;
        @(negedge clk);
        vecs++;
        if ({fft_start, in_ready, busy, out_valid} !== 4'b0010) begin
            errs++;
            $display("FAIL wait_done: start=%b in_ready=%b busy=%b ov=%b, want 0 0 1 0", fft_start, in_ready, busy, out_valid);
        end
    endtask

    // Pulses fft_done with out_ready held high; results must appear two cycles
    // after UNLOAD entry, one per cycle, last one tagged.
    task automatic unload_ready(input logic [AW-1:0] n_m1, input logic [7:0] base);
        int idx;
        logic exp_v;
        @(posedge clk); #1; fft_done = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; fft_done = 1'b0;
        for (int c = 0; c <= int'(n_m1) + 3; c++) begin
            @(negedge clk);
            idx = c - 2;
            exp_v = (c >= 2) && (c <= int'(n_m1) + 2);
            vecs++;
            if (out_valid !== exp_v ||
                (exp_v && (out_data !== base + 8'(idx) || out_last !== (idx == int'(n_m1)))) ||
                (c == int'(n_m1) + 3 && busy !== 1'b0)) begin
                errs++;
                $display("FAIL unload[c=%0d]: ov=%b od=%h last=%b busy=%b, want ov=%b od=%h last=%b",
                         c, out_valid, out_data, out_last, busy, exp_v, base + 8'(idx), idx == int'(n_m1));
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = start_cnt;
        load_frame(5'd7, 8'h40, 1'b1);
        repeat (DONE_DLY) @(negedge clk);
        vecs++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL wait_hold: ov=%b busy=%b err=%b in_ready=%b, want 0 1 0 0", out_valid, busy, err, in_ready);
        end
        unload_ready(5'd7, 8'h40);
        load_frame(5'd3, 8'hC0, 1'b0);
        repeat (4) @(posedge clk);
        unload_ready(5'd3, 8'hC0);
        vecs++;
        if (start_cnt - s0 != 2 || clash != 0) begin
            errs++;
            $display("FAIL start_count: starts=%0d clash=%0d, want 2 0", start_cnt - s0, clash);
        end
    endtask

    task automatic test_stall();
        int got;
        logic stalled;
        logic [7:0] held_d;
        logic held_l;
        got = 0; stalled = 1'b0; held_d = 8'h00; held_l = 1'b0;
        load_frame(5'd3, 8'h80, 1'b0);
        repeat (5) @(posedge clk);
        @(posedge clk); #1; fft_done = 1'b1;
        @(posedge clk); #1; fft_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c % 2 == 0);
            @(negedge clk);
            if (stalled) begin
                vecs++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    errs++;
                    $display("FAIL stall_hold[c=%0d]: ov=%b od=%h last=%b, want ov=1 od=%h last=%b",
                             c, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            if (out_valid === 1'b1) begin
                vecs++;
                if (got >= 4 || out_data !== 8'h80 + 8'(got) || out_last !== (got == 3)) begin
                    errs++;
                    $display("FAIL stall_data[%0d]: od=%h last=%b, want od=%h last=%b",
                             got, out_data, out_last, 8'h80 + 8'(got), got == 3);
                end
                if (out_ready) got++;
                stalled = !out_ready;
                held_d = out_data;
                held_l = out_last;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        vecs++;
        if (got != 4 || busy !== 1'b0) begin
            errs++;
            $display("FAIL stall_count: popped=%0d busy=%b, want 4 0", got, busy);
        end
    endtask

    task automatic test_n1();
        int s0;
        s0 = start_cnt;
        load_frame(5'd0, 8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        unload_ready(5'd0, 8'h5A);
        vecs++;
        if (start_cnt - s0 != 1) begin
            errs++;
            $display("FAIL n1_start: starts=%0d, want 1", start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
`ifdef FFT_CTRL_TIMEOUT_EN
        load_frame(5'd1, 8'h11, 1'b0);
        repeat (15) @(negedge clk);
        vecs++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL tmo_early: err=%b busy=%b, want 0 1", err, busy);
        end
        @(negedge clk);
        vecs++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL tmo_fire: err=%b busy=%b ov=%b, want 1 0 0", err, busy, out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1; fft_done = 1'b1;
        @(posedge clk); #1; fft_done = 1'b0;
        repeat (5) @(negedge clk);
        vecs++;
        if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL tmo_sticky: err=%b ov=%b busy=%b, want 1 0 0", err, out_valid, busy);
        end
        out_ready = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL tmo_clear: err=%b, want 0", err);
        end
        @(posedge clk); #1; rst = 1'b1;
`else
        repeat (2) @(negedge clk);
        vecs++;
        if (err !== 1'b0) begin
            errs++;
            $display("FAIL err_tied: err=%b, want 0", err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_back_to_back();
        test_stall();
        test_n1();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
